serclk_controller: RTL and testbench

- Configuration sequencer for the serial clock divider. It accepts speed writes from the Z80 register decode and waits until the serial engine is idle.
- It then holds the divider in reset, applies the new speed_select, lets the clock settle and reports ready.
- It also turns the divider output fed back to it into a one-cycle clk-domain tick enable for the serial shifters.

---
 rtl/serclk_pkg.sv | 24 ++
 rtl/serclk_controller_if.sv | 32 +++
 rtl/serclk_tick_detect.sv | 40 ++++
 rtl/serclk_controller.sv | 173 +++++++++++++++++
 tb/tb_serclk_controller.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/serclk_pkg.sv
// serclk_pkg
// Shared definitions for the serial clock configuration sequencer:
// FSM state encodings, speed field layout and the power-on speed.
// No ports (package).
package serclk_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_IDLE = 2'd1,
        RESET_GEN = 2'd2,
        SETTLE    = 2'd3
    } serclk_state_t;

    localparam int SPEED_DIV_BIT = 3;
    localparam int SPEED_TAP_MSB = 2;

    // Divided, tap 3: divide by 2^4.
    localparam logic [3:0] DEFAULT_SPEED = 4'b1011;

    function automatic logic speed_is_divided(input logic [3:0] speed);
        return speed[SPEED_DIV_BIT];
    endfunction

endpackage

// File: rtl/serclk_controller_if.sv
// serclk_controller_if
// Register-decode side of the sequencer: speed write strobe/data and the
// status readback (ready, pending, applied speed).
//   wr_en      one-cycle write strobe
//   wr_data    requested speed (bit 3 = divided, bits 2:0 = tap)
//   ready      no switch in progress and nothing pending
//   pending    a requested speed is waiting to be applied
//   cur_speed  applied speed readback
// master = register decode, slave = sequencer.
interface serclk_controller_if;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       ready;
    logic       pending;
    logic [3:0] cur_speed;

    modport master (
        output wr_en,
        output wr_data,
        input  ready,
        input  pending,
        input  cur_speed
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        output ready,
        output pending,
        output cur_speed
    );
endinterface

// File: rtl/serclk_tick_detect.sv
// serclk_tick_detect
// Turns the fed-back divider output into a one-cycle clk-domain enable.
//   clk, reset  system clock, async active-low reset
//   serclk_in   divider output, synchronous to clk
//   divided     1: detect rising edges of serclk_in; 0: divider passes clk
//               through, so every cycle is a tick
//   clear       clears the edge history so the first divided edge is seen
//   hold        forces tick low while the divider is being switched
//   tick        one-cycle enable per serial clock period
module serclk_tick_detect (
    input  logic clk,
    input  logic reset,
    input  logic serclk_in,
    input  logic divided,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
        end else if (clear) begin
            prev <= 1'b0;
        end else begin
            prev <= serclk_in;
        end
    end

    // Gated by reset so tick reads 0 while the block is held in reset.
    always_comb begin
        tick = 1'b0;
        if (reset && !hold) begin
            tick = divided ? (serclk_in & ~prev) : 1'b1;
        end
    end

endmodule

// File: rtl/serclk_controller.sv
// serclk_controller
// Configuration sequencer for the serial clock divider. A speed write is
// held pending until the serial engine is idle, then the divider is held
// in reset, the new speed applied, the clock allowed to settle, and ready
// reported. Also produces the shifter tick enable from the divider output.
// Optional build macro: SERCLK_CTRL_TIMEOUT_EN (forces the switch after
// TIMEOUT_CYCLES busy cycles and adds the sticky timeout_flag output).
// Ports:
//   clk           system (Z80) clock
//   reset         async active-low reset
//   bus           slave side of serclk_controller_if (write + status)
//   serial_busy   serial engine mid-frame; speed must not change
//   serclk_in     divider output fed back, synchronous to clk
//   speed_select  divider speed select
//   gen_reset     active-high divider reset pulse
//   tick          one-cycle enable per serial clock period
//   timeout_flag  (optional) sticky, forced switch happened; cleared on write
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | speed applied; leaves when a request is pending
// WAIT_IDLE | request pending, waiting for serial_busy to drop
// RESET_GEN | divider held in reset for RESET_CYCLES
// SETTLE    | new speed applied, waiting SETTLE_CYCLES for the clock
module serclk_controller #(
    parameter logic [3:0] DEFAULT_SPEED  = serclk_pkg::DEFAULT_SPEED,
    parameter int         RESET_CYCLES   = 2,
    parameter int         SETTLE_CYCLES  = 4,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                reset,
    serclk_controller_if.slave  bus,
    input  logic                serial_busy,
    input  logic                serclk_in,
    output logic [3:0]          speed_select,
    output logic                gen_reset,
    output logic                tick
`ifdef SERCLK_CTRL_TIMEOUT_EN
    ,output logic               timeout_flag
`endif
);

    import serclk_pkg::*;

    serclk_state_t state, state_nxt;
    logic [7:0]    cnt;
    logic [3:0]    pend_reg;
    logic          pending;
    logic          go;
    logic          cnt_zero;
    logic          write_ignored;
    logic          tick_clear;
    logic          tick_hold;

    assign cnt_zero      = (cnt == 8'd0);
    assign write_ignored = (state == IDLE) && (bus.wr_data == speed_select);

`ifdef SERCLK_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tcnt;
    logic          timeout_hit;

    // Down-counter reloaded outside WAIT_IDLE; hits zero on the
    // TIMEOUT_CYCLES-th busy cycle spent waiting.
    assign timeout_hit = (state == WAIT_IDLE) && serial_busy && (tcnt == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt         <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state != WAIT_IDLE) begin
                tcnt <= TW'(TIMEOUT_CYCLES - 1);
            end else if (serial_busy && tcnt != '0) begin
                tcnt <= tcnt - 1'b1;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end else if (bus.wr_en) begin
                timeout_flag <= 1'b0;
            end
        end
    end

    assign go = !serial_busy || timeout_hit;
`else
    assign go = !serial_busy;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (pending)  state_nxt = WAIT_IDLE;
            WAIT_IDLE: if (go)       state_nxt = RESET_GEN;
            RESET_GEN: if (cnt_zero) state_nxt = SETTLE;
            SETTLE:    if (cnt_zero) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready     = (state == IDLE) && !pending;
        bus.pending   = pending;
        bus.cur_speed = speed_select;
        tick_clear    = (state == RESET_GEN);
        tick_hold     = (state == RESET_GEN) || (state == SETTLE);
    end

    // Datapath registers updated alongside the state transitions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            speed_select <= DEFAULT_SPEED;
            pend_reg     <= DEFAULT_SPEED;
            pending      <= 1'b0;
            gen_reset    <= 1'b0;
            cnt          <= 8'd0;
        end else begin
            if (bus.wr_en) begin
                pend_reg <= bus.wr_data;
                if (!write_ignored) begin
                    pending <= 1'b1;
                end
            end
            unique case (state)
                WAIT_IDLE: begin
                    if (go) begin
                        gen_reset <= 1'b1;
                        cnt       <= 8'(RESET_CYCLES - 1);
                    end
                end
                RESET_GEN: begin
                    if (cnt_zero) begin
                        gen_reset    <= 1'b0;
                        speed_select <= pend_reg;
                        cnt          <= 8'(SETTLE_CYCLES - 1);
                        // A write landing on this edge stays pending.
                        if (!bus.wr_en) begin
                            pending <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                SETTLE: begin
                    if (!cnt_zero) begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    serclk_tick_detect u_tick (
        .clk       (clk),
        .reset     (reset),
        .serclk_in (serclk_in),
        .divided   (speed_is_divided(speed_select)),
        .clear     (tick_clear),
        .hold      (tick_hold),
        .tick      (tick)
    );

endmodule

// File: tb/tb_serclk_controller.sv
// tb_serclk_controller
// Directed bench for serclk_controller. A behavioural 8-bit divider model
// (cleared by gen_reset) feeds serclk_in from the selected tap.
module tb_serclk_controller;

    logic       clk;
    logic       reset;
    logic       serial_busy;
    logic       serclk_in;
    logic [3:0] speed_select;
    logic       gen_reset;
    logic       tick;
`ifdef SERCLK_CTRL_TIMEOUT_EN
    logic       timeout_flag;
`endif

    int tests;
    int failures;

    serclk_controller_if bus_if ();

    serclk_controller dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .serial_busy  (serial_busy),
        .serclk_in    (serclk_in),
        .speed_select (speed_select),
        .gen_reset    (gen_reset),
        .tick         (tick)
`ifdef SERCLK_CTRL_TIMEOUT_EN
        ,.timeout_flag (timeout_flag)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: free-running counter, held at zero by gen_reset.
    logic [7:0] div_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)         div_cnt <= 8'd0;
        else if (gen_reset) div_cnt <= 8'd0;
        else                div_cnt <= div_cnt + 8'd1;
    end
    assign serclk_in = div_cnt[speed_select[2:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] d);
        @(negedge clk);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = d;
        @(negedge clk);
        bus_if.wr_en   = 1'b0;
    endtask

    // Counts negedges until ready (bounded) and gen_reset-high cycles seen.
    task automatic wait_ready(input int limit, output int n, output int gr);
        n  = 0;
        gr = 0;
        while (!bus_if.ready && n < limit) begin
            @(negedge clk);
            n++;
            if (gen_reset) gr++;
        end
    endtask

    // Cycles between two consecutive ticks; -1 on timeout.
    task automatic tick_period(output int per);
        int n;
        per = -1;
        n   = 0;
        @(negedge clk);
        while (!tick && n < 600) begin
            @(negedge clk);
            n++;
        end
        if (tick) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!tick && n < 600);
            if (tick) per = n;
        end
    endtask

    initial begin
        int n, gr, per, ones;
        tests          = 0;
        failures       = 0;
        reset          = 1'b0;
        serial_busy    = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = 4'd0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_speed",   32'(speed_select), 32'hB);
        check("rst_genrst",  32'(gen_reset),    32'd0);
        check("rst_pending", 32'(bus_if.pending), 32'd0);
        check("rst_ready",   32'(bus_if.ready), 32'd1);
        check("rst_tick",    32'(tick),         32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready",   32'(bus_if.ready), 32'd1);
        check("rel_cur",     32'(bus_if.cur_speed), 32'hB);
        tick_period(per);
        check("period_16",   32'(per), 32'd16);

        // Switch to 4'b1000 with the engine idle
        do_write(4'b1000);
        check("w1_pending",  32'(bus_if.pending), 32'd1);
        check("w1_ready0",   32'(bus_if.ready), 32'd0);
        wait_ready(50, n, gr);
        check("w1_latency",  32'(n),  32'd8);
        check("w1_genrst",   32'(gr), 32'd2);
        check("w1_speed",    32'(speed_select), 32'h8);
        check("w1_cur",      32'(bus_if.cur_speed), 32'h8);
        tick_period(per);
        check("period_2",    32'(per), 32'd2);

        // Switch blocked by serial_busy
        serial_busy = 1'b1;
        do_write(4'b1111);
        gr = 0;
        repeat (50) begin
            @(negedge clk);
            if (gen_reset) gr++;
        end
        check("busy_pending", 32'(bus_if.pending), 32'd1);
        check("busy_ready",   32'(bus_if.ready), 32'd0);
        check("busy_speed",   32'(speed_select), 32'h8);
        check("busy_genrst",  32'(gr), 32'd0);
        serial_busy = 1'b0;
        wait_ready(50, n, gr);
        check("busy_done",    32'(bus_if.ready), 32'd1);
        check("busy_speed2",  32'(speed_select), 32'hF);
        tick_period(per);
        check("period_256",   32'(per), 32'd256);

        // Write during SETTLE queues a second switch
        do_write(4'b1010);
        repeat (4) @(negedge clk);
        check("settle_speed", 32'(speed_select), 32'hA);
        check("settle_tick",  32'(tick), 32'd0);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = 4'b1100;
        @(negedge clk);
        bus_if.wr_en   = 1'b0;
        check("settle_pend",  32'(bus_if.pending), 32'd1);
        wait_ready(50, n, gr);
        check("second_genrst", 32'(gr), 32'd2);
        check("second_speed",  32'(speed_select), 32'hC);
        tick_period(per);
        check("period_32",     32'(per), 32'd32);

        // Writing the applied speed in IDLE is ignored
        do_write(4'b1100);
        check("same_pending",  32'(bus_if.pending), 32'd0);
        check("same_ready",    32'(bus_if.ready), 32'd1);
        gr = 0;
        repeat (20) begin
            @(negedge clk);
            if (gen_reset) gr++;
        end
        check("same_genrst",   32'(gr), 32'd0);

        // Undivided speed: tick every cycle
        do_write(4'b0101);
        wait_ready(50, n, gr);
        check("undiv_speed",   32'(speed_select), 32'h5);
        ones = 0;
        repeat (10) begin
            @(negedge clk);
            if (tick) ones++;
        end
        check("undiv_ticks",   32'(ones), 32'd10);

        // Reset asserted during RESET_GEN aborts the switch
        do_write(4'b1110);
        n = 0;
        while (!gen_reset && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_rg",   32'(gen_reset), 32'd1);
        check("abort_tickhold", 32'(tick), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_genrst",  32'(gen_reset), 32'd0);
        check("abort_speed",   32'(speed_select), 32'hB);
        check("abort_pending", 32'(bus_if.pending), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check("abort_ready",   32'(bus_if.ready), 32'd1);
        check("abort_speed2",  32'(speed_select), 32'hB);
        tick_period(per);
        check("abort_period",  32'(per), 32'd16);

`ifdef SERCLK_CTRL_TIMEOUT_EN
        check("to_flag0",      32'(timeout_flag), 32'd0);
        serial_busy = 1'b1;
        do_write(4'b1001);
        n = 0;
        while (!gen_reset && n < 1200) begin
            @(negedge clk);
            n++;
        end
        check("to_forced_at",  32'(n), 32'd1025);
        check("to_flag1",      32'(timeout_flag), 32'd1);
        wait_ready(50, n, gr);
        check("to_speed",      32'(speed_select), 32'h9);
        check("to_flag_sticky", 32'(timeout_flag), 32'd1);
        serial_busy = 1'b0;
        do_write(4'b1001);
        check("to_flag_clr",   32'(timeout_flag), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
